// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch requester (fs) and the load/store requester (ls). Load/store has fixed
// priority, but a fetch that keeps losing arbitration is forced through after
// STARVE_MAX contended cycles. Only one memory transaction is outstanding.
// Optional feature: define ARB_PERF_CNT_EN to enable the wait-cycle counters
// on perf_fs_wait / perf_ls_wait. Without it both ports are tied to 0.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fs_req,
  input  logic [ADDR_W-1:0]   fs_addr,
  output logic                fs_ready,
  output logic                fs_resp_valid,
  output logic [DATA_W-1:0]   fs_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_ready,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [31:0]         perf_fs_wait,
  output logic [31:0]         perf_ls_wait
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {OWN_FS, OWN_LS} owner_e;

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       sel_fs;
  logic       sel_ls;

  // Arbitration, request muxing, response routing and next-state; reset blanks all outputs
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    starve_cnt_d  = starve_cnt_q;
    sel_fs        = 1'b0;
    sel_ls        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = '0;
    fs_ready      = 1'b0;
    ls_ready      = 1'b0;
    fs_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    fs_rdata      = '0;
    ls_rdata      = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          sel_fs = fs_req && (!ls_req || starve_cnt_q == STARVE_LIM);
          sel_ls = ls_req && !sel_fs;
          if (sel_fs) begin
            mem_req  = 1'b1;
            mem_addr = fs_addr;
          end else if (sel_ls) begin
            mem_req   = 1'b1;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_wstrb = ls_wstrb;
          end
          fs_ready = sel_fs && mem_ready;
          ls_ready = sel_ls && mem_ready;
          if (mem_req && mem_ready) begin
            state_d = BUSY;
            owner_d = sel_ls ? OWN_LS : OWN_FS;
          end
          if (sel_fs && mem_ready) begin
            starve_cnt_d = '0;
          end else if (fs_req && sel_ls && starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
        BUSY: begin
          if (mem_resp_valid) begin
            state_d = IDLE;
            if (owner_q == OWN_LS) begin
              ls_resp_valid = 1'b1;
              ls_rdata      = mem_rdata;
            end else begin
              fs_resp_valid = 1'b1;
              fs_rdata      = mem_rdata;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, owner and starvation counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_FS;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_fs_wait_q, perf_fs_wait_d;
  logic [31:0] perf_ls_wait_q, perf_ls_wait_d;

  // Count every cycle a requester is asking but not being accepted
  always_comb begin
    perf_fs_wait_d = perf_fs_wait_q + {31'd0, fs_req && !fs_ready};
    perf_ls_wait_d = perf_ls_wait_q + {31'd0, ls_req && !ls_ready};
  end

  // Wait-cycle counter registers, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fs_wait_q <= '0;
      perf_ls_wait_q <= '0;
    end else begin
      perf_fs_wait_q <= perf_fs_wait_d;
      perf_ls_wait_q <= perf_ls_wait_d;
    end
  end

  assign perf_fs_wait = reset ? 32'd0 : perf_fs_wait_q;
  assign perf_ls_wait = reset ? 32'd0 : perf_ls_wait_q;
`else
  assign perf_fs_wait = 32'd0;
  assign perf_ls_wait = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus for mem_port_arbiter, with a
// transaction-level reference model compared every cycle plus literal checks.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
`ifdef ARB_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        fs_req;
  logic [63:0] fs_addr;
  logic        fs_ready;
  logic        fs_resp_valid;
  logic [63:0] fs_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wstrb;
  logic        ls_ready;
  logic        ls_resp_valid;
  logic [63:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;
  logic [31:0] perf_fs_wait;
  logic [31:0] perf_ls_wait;

  int nCompared = 0;
  int nMismatched = 0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .fs_req(fs_req), .fs_addr(fs_addr), .fs_ready(fs_ready),
    .fs_resp_valid(fs_resp_valid), .fs_rdata(fs_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_ready(ls_ready), .ls_resp_valid(ls_resp_valid),
    .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata),
    .perf_fs_wait(perf_fs_wait), .perf_ls_wait(perf_ls_wait)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic f, input logic l, input logic we,
                               input logic mr, input logic mrv, input logic [63:0] rd);
    @(posedge clk);
    #1;
    reset          = rst;
    fs_req         = f;
    ls_req         = l;
    ls_we          = we;
    mem_ready      = mr;
    mem_resp_valid = mrv;
    mem_rdata      = rd;
    @(negedge clk);
  endtask

  // Reference model: one outstanding transaction, owner remembered, losing-streak count for fetch
  bit          mBusy = 1'b0;
  bit          mOwnerLs = 1'b0;
  int          mStarve = 0;
  logic [31:0] mPerfFs = '0;
  logic [31:0] mPerfLs = '0;

  // Compare process: predict outputs from the model at each falling edge, then advance the model
  always @(negedge clk) begin
    bit          fsWins, lsWins;
    logic        eReq, eWe, eFsRdy, eLsRdy, eFsRv, eLsRv;
    logic [63:0] eAddr, eWdata, eFsRd, eLsRd;
    logic [7:0]  eStrb;
    fsWins = 1'b0; lsWins = 1'b0;
    eReq = 1'b0; eWe = 1'b0; eFsRdy = 1'b0; eLsRdy = 1'b0; eFsRv = 1'b0; eLsRv = 1'b0;
    eAddr = '0; eWdata = '0; eFsRd = '0; eLsRd = '0; eStrb = '0;
    if (!reset) begin
      if (!mBusy) begin
        fsWins = fs_req && (!ls_req || mStarve == STARVE_MAX);
        lsWins = ls_req && !fsWins;
        eReq   = fsWins || lsWins;
        eFsRdy = fsWins && mem_ready;
        eLsRdy = lsWins && mem_ready;
        if (fsWins) eAddr = fs_addr;
        if (lsWins) begin
          eAddr = ls_addr; eWe = ls_we; eWdata = ls_wdata; eStrb = ls_wstrb;
        end
      end else if (mem_resp_valid) begin
        if (mOwnerLs) begin eLsRv = 1'b1; eLsRd = mem_rdata; end
        else          begin eFsRv = 1'b1; eFsRd = mem_rdata; end
      end
    end
    checkOutput("mem_req",       {63'd0, mem_req},       {63'd0, eReq});
    checkOutput("mem_we",        {63'd0, mem_we},        {63'd0, eWe});
    checkOutput("mem_addr",      mem_addr,               eAddr);
    checkOutput("mem_wdata",     mem_wdata,              eWdata);
    checkOutput("mem_wstrb",     {56'd0, mem_wstrb},     {56'd0, eStrb});
    checkOutput("fs_ready",      {63'd0, fs_ready},      {63'd0, eFsRdy});
    checkOutput("ls_ready",      {63'd0, ls_ready},      {63'd0, eLsRdy});
    checkOutput("fs_resp_valid", {63'd0, fs_resp_valid}, {63'd0, eFsRv});
    checkOutput("ls_resp_valid", {63'd0, ls_resp_valid}, {63'd0, eLsRv});
    checkOutput("fs_rdata",      fs_rdata,               eFsRd);
    checkOutput("ls_rdata",      ls_rdata,               eLsRd);
    checkOutput("perf_fs_wait",  {32'd0, perf_fs_wait},  {32'd0, reset ? 32'd0 : mPerfFs});
    checkOutput("perf_ls_wait",  {32'd0, perf_ls_wait},  {32'd0, reset ? 32'd0 : mPerfLs});
    if (reset) begin
      mBusy = 1'b0; mStarve = 0; mPerfFs = '0; mPerfLs = '0;
    end else begin
      if (PERF_EN && fs_req && !eFsRdy) mPerfFs = mPerfFs + 32'd1;
      if (PERF_EN && ls_req && !eLsRdy) mPerfLs = mPerfLs + 32'd1;
      if (!mBusy) begin
        if (eReq && mem_ready) begin
          mBusy = 1'b1; mOwnerLs = lsWins;
        end
        if (fsWins && mem_ready) mStarve = 0;
        else if (fs_req && ls_req) mStarve = (mStarve + 1 > STARVE_MAX) ? STARVE_MAX : mStarve + 1;
      end else if (mem_resp_valid) begin
        mBusy = 1'b0;
      end
    end
  end

  // Directed scenarios with hand-computed literal expectations
  initial begin
    reset = 1'b1; fs_req = 1'b1; fs_addr = 64'h8000_0000;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    mem_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = '0;

    // Reset with a fetch held: nothing may be granted
    @(negedge clk);
    checkOutput("rst_fs_ready", {63'd0, fs_ready}, 64'd0);
    checkOutput("rst_mem_req",  {63'd0, mem_req},  64'd0);
    applyStimulus(1, 0, 0, 0, 1, 0, 64'h0);

    // Single fetch, response three cycles later
    fs_addr = 64'h8000_0000;
    applyStimulus(0, 1, 0, 0, 1, 0, 64'h0);
    checkOutput("fetch_fs_ready", {63'd0, fs_ready}, 64'd1);
    checkOutput("fetch_mem_we",   {63'd0, mem_we},   64'd0);
    checkOutput("fetch_mem_addr", mem_addr,          64'h8000_0000);
    applyStimulus(0, 0, 0, 0, 1, 0, 64'h0);
    checkOutput("fetch_busy_req", {63'd0, mem_req},  64'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, 64'h0);
    applyStimulus(0, 0, 0, 0, 1, 1, 64'h13);
    checkOutput("fetch_resp_valid", {63'd0, fs_resp_valid}, 64'd1);
    checkOutput("fetch_rdata",      fs_rdata,               64'h13);
    checkOutput("fetch_ls_resp",    {63'd0, ls_resp_valid}, 64'd0);
    applyStimulus(0, 0, 0, 0, 1, 1, 64'h55);
    checkOutput("idle_resp_ignored", {63'd0, fs_resp_valid}, 64'd0);

    // Collision: store wins, fetch follows after the store response
    applyStimulus(1, 0, 0, 0, 1, 0, 64'h0);
    fs_addr = 64'h1000; ls_addr = 64'h100; ls_wdata = 64'hDEAD; ls_wstrb = 8'hFF;
    applyStimulus(0, 1, 1, 1, 1, 0, 64'h0);
    checkOutput("coll_ls_ready", {63'd0, ls_ready}, 64'd1);
    checkOutput("coll_fs_ready", {63'd0, fs_ready}, 64'd0);
    checkOutput("coll_mem_we",   {63'd0, mem_we},   64'd1);
    checkOutput("coll_addr",     mem_addr,          64'h100);
    checkOutput("coll_wdata",    mem_wdata,         64'hDEAD);
    checkOutput("coll_wstrb",    {56'd0, mem_wstrb}, 64'hFF);
    applyStimulus(0, 1, 0, 0, 1, 1, 64'h77);
    checkOutput("coll_ls_resp",  {63'd0, ls_resp_valid}, 64'd1);
    applyStimulus(0, 1, 0, 0, 1, 0, 64'h0);
    checkOutput("coll_fs_grant", {63'd0, fs_ready}, 64'd1);
    checkOutput("coll_fs_addr",  mem_addr,          64'h1000);
    applyStimulus(0, 0, 0, 0, 1, 1, 64'h99);
    checkOutput("coll_fs_rdata", fs_rdata,          64'h99);

    // Starvation: four ls wins, then fetch forced on the fifth contended IDLE cycle
    applyStimulus(1, 0, 0, 0, 1, 0, 64'h0);
    fs_addr = 64'h2000; ls_addr = 64'h300;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 1, 0, 1, 0, 64'h0);
      checkOutput("starve_ls_win", {63'd0, ls_ready}, 64'd1);
      applyStimulus(0, 1, 1, 0, 1, 1, 64'h10 + 64'(k));
      checkOutput("starve_ls_resp", {63'd0, ls_resp_valid}, 64'd1);
    end
    applyStimulus(0, 1, 1, 0, 1, 0, 64'h0);
    checkOutput("starve_fs_forced", {63'd0, fs_ready}, 64'd1);
    checkOutput("starve_ls_held",   {63'd0, ls_ready}, 64'd0);
    checkOutput("starve_fs_addr",   mem_addr,          64'h2000);
    applyStimulus(0, 0, 1, 0, 1, 1, 64'hAB);
    checkOutput("starve_fs_rdata",  fs_rdata,          64'hAB);
    applyStimulus(0, 1, 1, 0, 1, 0, 64'h0);
    checkOutput("starve_cleared",   {63'd0, ls_ready}, 64'd1);
    applyStimulus(0, 0, 0, 0, 1, 1, 64'h0);

    // Backpressure on a load: three refused cycles, then accepted
    applyStimulus(1, 0, 0, 0, 1, 0, 64'h0);
    ls_addr = 64'h200;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 64'h0);
      checkOutput("bp_mem_req",  {63'd0, mem_req},  64'd1);
      checkOutput("bp_mem_addr", mem_addr,          64'h200);
      checkOutput("bp_ls_ready", {63'd0, ls_ready}, 64'd0);
    end
    applyStimulus(0, 0, 1, 0, 1, 0, 64'h0);
    checkOutput("bp_accept", {63'd0, ls_ready}, 64'd1);
    applyStimulus(0, 0, 0, 0, 1, 1, 64'h42);
    checkOutput("bp_ls_rdata", ls_rdata, 64'h42);
    checkOutput("bp_perf_ls", {32'd0, perf_ls_wait}, PERF_EN ? 64'd3 : 64'd0);
    checkOutput("bp_perf_fs", {32'd0, perf_fs_wait}, 64'd0);

    // Reset while a fetch is outstanding, with a new fetch held; late response dropped
    fs_addr = 64'h4000;
    applyStimulus(0, 1, 0, 0, 1, 0, 64'h0);
    checkOutput("rb_fs_ready", {63'd0, fs_ready}, 64'd1);
    applyStimulus(1, 1, 0, 0, 1, 0, 64'h0);
    checkOutput("rb_rst_ready", {63'd0, fs_ready}, 64'd0);
    checkOutput("rb_rst_req",   {63'd0, mem_req},  64'd0);
    applyStimulus(0, 0, 0, 0, 1, 1, 64'hEE);
    checkOutput("rb_fs_resp", {63'd0, fs_resp_valid}, 64'd0);
    checkOutput("rb_ls_resp", {63'd0, ls_resp_valid}, 64'd0);
    checkOutput("rb_fs_rdata", fs_rdata, 64'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, 64'h0);
    applyStimulus(0, 0, 0, 0, 1, 0, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the instruction-fetch requester (fs) and the load/store requester (ls).
- Fixed priority to ls, with a starvation guard that forces a fetch grant after a bounded wait.
- Allows one outstanding memory transaction at a time.
- Sits between the IF/MEM stages and the memory port. Stage stall signals are derived from the req/ready handshakes below.

Parameters:
- ADDR_W, 64, address width of both requesters and the memory port.
- DATA_W, 64, data width; write strobe width is DATA_W/8.
- STARVE_MAX, 4, consecutive cycles fs may lose arbitration before it gets forced priority; legal range 1..15.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- fs_req  input  1  fetch request valid.
- fs_addr  input  ADDR_W  fetch address.
- fs_ready  output  1  fetch request accepted this cycle.
- fs_resp_valid  output  1  fetch read data valid, one-cycle pulse.
- fs_rdata  output  DATA_W  fetch read data.
- ls_req  input  1  load/store request valid.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  ADDR_W  load/store address.
- ls_wdata  input  DATA_W  store data.
- ls_wstrb  input  DATA_W/8  store byte enables.
- ls_ready  output  1  load/store request accepted this cycle.
- ls_resp_valid  output  1  load data / store completion, one-cycle pulse.
- ls_rdata  output  DATA_W  load data.
- mem_req  output  1  memory request valid.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_wstrb  output  DATA_W/8  memory byte enables.
- mem_ready  input  1  memory accepts request.
- mem_resp_valid  input  1  memory response valid.
- mem_rdata  input  DATA_W  memory read data.
- perf_fs_wait  output  32  fetch wait-cycle counter (see Optional Feature).
- perf_ls_wait  output  32  load/store wait-cycle counter (see Optional Feature).

Behaviour:
- FSM states are IDLE and BUSY. Reset puts the FSM in IDLE, clears owner and starve_cnt, and drives every output to 0.
- Request rules: a requester holds req and its payload stable until it sees its ready. Ready is asserted only in IDLE.
- Selection in IDLE:
  - sel = fs if fs_req && (!ls_req || starve_cnt == STARVE_MAX).
  - Otherwise sel = ls if ls_req.
  - Otherwise no selection and mem_req = 0.
- mem_* outputs in IDLE are driven combinationally from sel in the same cycle (zero-cycle request latency).
- For a fs selection, mem_we = 0 and mem_wstrb = 0.
- Payload outputs are 0 when no request is selected.
- ready rule: fs_ready / ls_ready = sel matches && mem_ready. A handshake is mem_req && mem_ready.
- On handshake: owner <= sel and the FSM goes to BUSY. Without mem_ready the FSM stays in IDLE and selection is re-evaluated next cycle.
- In BUSY:
  - mem_req = 0 and both readies are 0.
  - On mem_resp_valid, the response is routed combinationally to the owner: fs_resp_valid or ls_resp_valid = 1 and the matching rdata = mem_rdata. The FSM returns to IDLE.
  - The next request can be accepted in the cycle after the response, giving a minimum of 2 cycles per transaction.
- The non-owner rdata is 0. A mem_resp_valid seen in IDLE is ignored.
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_MAX, in each IDLE cycle with fs_req && ls_req where sel = ls.
  - Clears on a fs handshake.
  - Holds in BUSY and in all other cycles.
- Simultaneous fs_req and ls_req with starve_cnt < STARVE_MAX: ls wins.
- A store response still pulses ls_resp_valid; ls_rdata then carries mem_rdata, which the consumer ignores.
- Reset during BUSY: the FSM returns to IDLE, and any later mem_resp_valid for the aborted transaction is dropped.
- Reset during a held request: no ready is issued in the reset cycle.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined:
  - perf_fs_wait increments each cycle fs_req && !fs_ready.
  - perf_ls_wait increments each cycle ls_req && !ls_ready.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- When undefined: both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Single fetch: fs_req, fs_addr=0x80000000, mem_ready=1, response 3 cycles later with rdata=0x00000013 -> fs_ready pulses in cycle 0, mem_we=0, fs_resp_valid=1 with fs_rdata=0x13 in cycle 3, ls_resp_valid stays 0.
- Collision: fs_req and ls_req (store, addr 0x100, wdata 0xDEAD, wstrb 0xFF) in the same cycle -> ls granted first with mem_we=1; fs granted the cycle after the ls response.
- Starvation, STARVE_MAX=4: ls_req held continuously with 1-cycle memory latency while fs_req is held -> fs granted on its 5th contended IDLE cycle, starve_cnt returns to 0.
- Backpressure: mem_ready=0 for 3 cycles while ls_req is asserted -> mem_req stays 1 with a stable payload and ls_ready=0; the handshake completes on the cycle mem_ready=1.
- Reset in BUSY: assert reset while waiting on a fetch, then pulse mem_resp_valid -> no fs_resp_valid or ls_resp_valid, FSM in IDLE, all outputs 0.
- ARB_PERF_CNT_EN defined, backpressure case above -> perf_ls_wait=3. Undefined -> perf_ls_wait=0.
